// File: rtl/accum_scheduler_pkg.sv
// Shared field widths, exponent limit and FSM state encoding for the
// floating-point accumulation scheduler.
package accum_scheduler_pkg;

  localparam int SIGN_W = 1;
  localparam int EXP_W  = 6;
  localparam int MAN_W  = 12;

  localparam logic [EXP_W-1:0] EXP_MAX = 6'd63;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    ISSUE   = 3'd2,
    WAIT    = 3'd3,
    CAPTURE = 3'd4,
    DONE    = 3'd5
  } state_e;

endpackage

// File: rtl/accum_normalize.sv
// Combinational post-processing of one adder result before it is written
// back into the accumulator: carry renormalisation, saturation, zero cleanup.
module accum_normalize
  import accum_scheduler_pkg::*;
(
  input  logic             aSign_i,
  input  logic             bSign_i,
  input  logic             addSign_i,
  input  logic [EXP_W-1:0] addExponent_i,
  input  logic [MAN_W-1:0] addMantissa_i,
  input  logic             addCout_i,
  output logic             sign_o,
  output logic [EXP_W-1:0] exponent_o,
  output logic [MAN_W-1:0] mantissa_o,
  output logic             sat_o
);

  // A carry only means mantissa overflow for an effective addition; for an
  // effective subtraction the adder's carry is meaningless.
  always_comb begin
    sign_o     = addSign_i;
    exponent_o = addExponent_i;
    mantissa_o = addMantissa_i;
    sat_o      = 1'b0;
    if ((aSign_i == bSign_i) && addCout_i) begin
      if (addExponent_i == EXP_MAX) begin
        exponent_o = EXP_MAX;
        mantissa_o = '1;
        sat_o      = 1'b1;
      end else begin
        exponent_o = addExponent_i + EXP_W'(1);
        mantissa_o = {1'b1, addMantissa_i[MAN_W-1:1]};
      end
    end
    if (mantissa_o == '0) begin
      sign_o     = 1'b0;
      exponent_o = '0;
    end
  end

endmodule

// File: rtl/accum_scheduler.sv
// Streams terms through a single external adder, folding them into an
// accumulator one add at a time and presenting the finished sum.
module accum_scheduler
  import accum_scheduler_pkg::*;
#(
  parameter int ADD_LAT = 2,
  parameter int CNT_W   = 6
) (
  input  logic             Clock_i,
  input  logic             Reset_i,
  input  logic             InValid_i,
  output logic             InReady_o,
  input  logic             InSign_i,
  input  logic [EXP_W-1:0] InExponent_i,
  input  logic [MAN_W-1:0] InMantissa_i,
  input  logic             InLast_i,
  output logic             AddSignA_o,
  output logic             AddSignB_o,
  output logic [EXP_W-1:0] AddExponentA_o,
  output logic [EXP_W-1:0] AddExponentB_o,
  output logic [MAN_W-1:0] AddMantissaA_o,
  output logic [MAN_W-1:0] AddMantissaB_o,
  input  logic             AddSignOut_i,
  input  logic [EXP_W-1:0] AddExponentOut_i,
  input  logic [MAN_W-1:0] AddMantissaOut_i,
  input  logic             AddCout_i,
  output logic             OutValid_o,
  input  logic             OutReady_i,
  output logic             OutSign_o,
  output logic [EXP_W-1:0] OutExponent_o,
  output logic [MAN_W-1:0] OutMantissa_o,
  output logic [CNT_W-1:0] OutCount_o,
  output logic             OutSat_o
);

  localparam int WAIT_W = $clog2(ADD_LAT + 2);

  state_e             state_q, state_d;
  logic               accSign_q, accSign_d;
  logic [EXP_W-1:0]   accExp_q, accExp_d;
  logic [MAN_W-1:0]   accMan_q, accMan_d;
  logic               bSign_q, bSign_d;
  logic [EXP_W-1:0]   bExp_q, bExp_d;
  logic [MAN_W-1:0]   bMan_q, bMan_d;
  logic               bLast_q, bLast_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               sat_q, sat_d;
  logic [WAIT_W-1:0]  waitCnt_q, waitCnt_d;

  logic               normSign;
  logic [EXP_W-1:0]   normExp;
  logic [MAN_W-1:0]   normMan;
  logic               normSat;

  accum_normalize uNormalize (
    .aSign_i       (accSign_q),
    .bSign_i       (bSign_q),
    .addSign_i     (AddSignOut_i),
    .addExponent_i (AddExponentOut_i),
    .addMantissa_i (AddMantissaOut_i),
    .addCout_i     (AddCout_i),
    .sign_o        (normSign),
    .exponent_o    (normExp),
    .mantissa_o    (normMan),
    .sat_o         (normSat)
  );

  // Operands come straight from registers that only change in IDLE, FETCH
  // and CAPTURE, so they are frozen for the whole ISSUE/WAIT window.
  assign AddSignA_o     = accSign_q;
  assign AddExponentA_o = accExp_q;
  assign AddMantissaA_o = accMan_q;
  assign AddSignB_o     = bSign_q;
  assign AddExponentB_o = bExp_q;
  assign AddMantissaB_o = bMan_q;

  assign InReady_o     = (state_q == IDLE) || (state_q == FETCH);
  assign OutValid_o    = (state_q == DONE);
  assign OutSign_o     = accSign_q;
  assign OutExponent_o = accExp_q;
  assign OutMantissa_o = accMan_q;
  assign OutCount_o    = count_q;
  assign OutSat_o      = sat_q;

  always_comb begin
    state_d   = state_q;
    accSign_d = accSign_q;
    accExp_d  = accExp_q;
    accMan_d  = accMan_q;
    bSign_d   = bSign_q;
    bExp_d    = bExp_q;
    bMan_d    = bMan_q;
    bLast_d   = bLast_q;
    count_d   = count_q;
    sat_d     = sat_q;
    waitCnt_d = waitCnt_q;
    unique case (state_q)
      IDLE: begin
        if (InValid_i) begin
          accSign_d = InSign_i;
          accExp_d  = InExponent_i;
          accMan_d  = InMantissa_i;
          count_d   = CNT_W'(1);
          state_d   = InLast_i ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (InValid_i) begin
          bSign_d = InSign_i;
          bExp_d  = InExponent_i;
          bMan_d  = InMantissa_i;
          bLast_d = InLast_i;
          state_d = ISSUE;
        end
      end
      // ISSUE plus ADD_LAT cycles of WAIT give the adder its full latency.
      ISSUE: begin
        if (ADD_LAT == 0) begin
          state_d = CAPTURE;
        end else begin
          waitCnt_d = WAIT_W'(1);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (waitCnt_q == WAIT_W'(ADD_LAT)) begin
          state_d = CAPTURE;
        end else begin
          waitCnt_d = waitCnt_q + WAIT_W'(1);
        end
      end
      CAPTURE: begin
        accSign_d = normSign;
        accExp_d  = normExp;
        accMan_d  = normMan;
        sat_d     = sat_q | normSat;
        if (count_q != '1) begin
          count_d = count_q + CNT_W'(1);
        end
        state_d = bLast_q ? DONE : FETCH;
      end
      DONE: begin
        if (OutReady_i) begin
          sat_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock_i or posedge Reset_i) begin
    if (Reset_i) begin
      state_q   <= IDLE;
      accSign_q <= 1'b0;
      accExp_q  <= '0;
      accMan_q  <= '0;
      bSign_q   <= 1'b0;
      bExp_q    <= '0;
      bMan_q    <= '0;
      bLast_q   <= 1'b0;
      count_q   <= '0;
      sat_q     <= 1'b0;
      waitCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      accSign_q <= accSign_d;
      accExp_q  <= accExp_d;
      accMan_q  <= accMan_d;
      bSign_q   <= bSign_d;
      bExp_q    <= bExp_d;
      bMan_q    <= bMan_d;
      bLast_q   <= bLast_d;
      count_q   <= count_d;
      sat_q     <= sat_d;
      waitCnt_q <= waitCnt_d;
    end
  end

endmodule

// File: tb/tb_accum_scheduler.sv
// Bench for accum_scheduler: a pipelined behavioural adder, a reference
// fold of each sum's terms, directed corner cases and random sums.
module tb_accum_scheduler;

  localparam int ADD_LAT = 2;
  localparam int CNT_W   = 6;
  localparam int MAX_T   = 70;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        InValid, InReady, InSign, InLast;
  logic [5:0]  InExponent;
  logic [11:0] InMantissa;
  logic        AddSignA, AddSignB, AddSignOut, AddCout;
  logic [5:0]  AddExponentA, AddExponentB, AddExponentOut;
  logic [11:0] AddMantissaA, AddMantissaB, AddMantissaOut;
  logic        OutValid, OutReady, OutSign, OutSat;
  logic [5:0]  OutExponent;
  logic [11:0] OutMantissa;
  logic [CNT_W-1:0] OutCount;

  logic        tSign [MAX_T];
  logic [5:0]  tExp  [MAX_T];
  logic [11:0] tMan  [MAX_T];

  int assertCount = 0;
  int failCount   = 0;
  int cyc         = 0;

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  accum_scheduler #(.ADD_LAT(ADD_LAT), .CNT_W(CNT_W)) dut (
    .Clock_i(Clock), .Reset_i(Reset),
    .InValid_i(InValid), .InReady_o(InReady),
    .InSign_i(InSign), .InExponent_i(InExponent), .InMantissa_i(InMantissa),
    .InLast_i(InLast),
    .AddSignA_o(AddSignA), .AddSignB_o(AddSignB),
    .AddExponentA_o(AddExponentA), .AddExponentB_o(AddExponentB),
    .AddMantissaA_o(AddMantissaA), .AddMantissaB_o(AddMantissaB),
    .AddSignOut_i(AddSignOut), .AddExponentOut_i(AddExponentOut),
    .AddMantissaOut_i(AddMantissaOut), .AddCout_i(AddCout),
    .OutValid_o(OutValid), .OutReady_i(OutReady),
    .OutSign_o(OutSign), .OutExponent_o(OutExponent), .OutMantissa_o(OutMantissa),
    .OutCount_o(OutCount), .OutSat_o(OutSat)
  );

  // Adder result packed as {sign, exponent, mantissa, cout}; subtraction
  // always reports cout=1 so a design that honours it gets caught.
  function automatic logic [19:0] fpAdd(input logic sa, input logic [5:0] ea, input logic [11:0] ma,
                                        input logic sb, input logic [5:0] eb, input logic [11:0] mb);
    int mas, mbs, sum;
    logic [5:0] e;
    logic s, c;
    if (ea >= eb) begin
      e = ea; mas = int'(ma); mbs = int'(mb >> (ea - eb));
    end else begin
      e = eb; mbs = int'(mb); mas = int'(ma >> (eb - ea));
    end
    if (sa == sb) begin
      sum = mas + mbs; s = sa; c = (sum >= 4096);
    end else begin
      c = 1'b1;
      if (mas >= mbs) begin sum = mas - mbs; s = sa; end
      else begin sum = mbs - mas; s = sb; end
    end
    return {s, e, 12'(sum), c};
  endfunction

  logic [19:0] addPipe [ADD_LAT];
  always @(posedge Clock) begin
    addPipe[0] <= fpAdd(AddSignA, AddExponentA, AddMantissaA, AddSignB, AddExponentB, AddMantissaB);
    for (int i = 1; i < ADD_LAT; i++) addPipe[i] <= addPipe[i-1];
  end
  assign {AddSignOut, AddExponentOut, AddMantissaOut, AddCout} = addPipe[ADD_LAT-1];

  // Reference: fold the term list left to right with the capture rules.
  function automatic void modelSum(input int n, output logic s, output logic [5:0] e,
                                   output logic [11:0] m, output int cnt, output logic sat);
    logic [19:0] r;
    int ne;
    s = tSign[0]; e = tExp[0]; m = tMan[0]; sat = 1'b0;
    for (int k = 1; k < n; k++) begin
      r = fpAdd(s, e, m, tSign[k], tExp[k], tMan[k]);
      if ((s == tSign[k]) && r[0]) begin
        ne = int'(r[18:13]) + 1;
        if (ne > 63) begin e = 6'd63; m = 12'hFFF; sat = 1'b1; end
        else begin e = ne[5:0]; m = 12'h800 | (r[12:1] >> 1); end
      end else begin
        e = r[18:13]; m = r[12:1];
      end
      s = r[19];
      if (m == 12'h000) begin s = 1'b0; e = 6'd0; end
    end
    cnt = (n > CNT_MAX) ? CNT_MAX : n;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic setTerm(input int k, input logic s, input logic [5:0] e, input logic [11:0] m);
    tSign[k] = s; tExp[k] = e; tMan[k] = m;
  endtask

  // Runs one complete sum from IDLE through the DONE handshake; entered and
  // left on a falling edge.
  task automatic applyStimulus(input string tag, input int n, input bit gaps, input int readyDelay);
    int first, budget, lat;
    bit allHeld;
    logic expS, expSat;
    logic [5:0] expE;
    logic [11:0] expM;
    int expC;
    modelSum(n, expS, expE, expM, expC, expSat);
    allHeld = 1'b1;
    first = 0;
    for (int k = 0; k < n; k++) begin
      if (gaps && k > 0 && $urandom_range(0, 3) == 0) begin
        InValid = 1'b0;
        allHeld = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge Clock);
      end
      InValid = 1'b1; InSign = tSign[k]; InExponent = tExp[k]; InMantissa = tMan[k];
      InLast = (k == n - 1);
      budget = 0;
      while (InReady !== 1'b1 && budget < 50) begin @(negedge Clock); budget++; end
      if (budget >= 50) begin
        checkOutput($sformatf("%s_acceptTimeout", tag), 32'(InReady), 32'd1);
        InValid = 1'b0;
        return;
      end
      @(posedge Clock);
      @(negedge Clock);
      if (k == 0) first = cyc;
    end
    InValid = 1'b0; InLast = 1'b0;
    budget = 0;
    while (OutValid !== 1'b1 && budget < 2000) begin @(negedge Clock); budget++; end
    if (budget >= 2000) begin
      checkOutput($sformatf("%s_doneTimeout", tag), 32'(OutValid), 32'd1);
      return;
    end
    lat = cyc - first + 1;
    if (allHeld) checkOutput($sformatf("%s_latency", tag), 32'(lat), 32'(1 + (n - 1) * (ADD_LAT + 3)));
    checkOutput($sformatf("%s_sum", tag), {13'd0, OutSign, OutExponent, OutMantissa}, {13'd0, expS, expE, expM});
    checkOutput($sformatf("%s_count", tag), 32'(OutCount), 32'(expC));
    checkOutput($sformatf("%s_sat", tag), 32'(OutSat), 32'(expSat));
    checkOutput($sformatf("%s_inReadyDone", tag), 32'(InReady), 32'd0);
    for (int d = 0; d < readyDelay; d++) begin
      @(negedge Clock);
      checkOutput($sformatf("%s_hold%0d", tag, d),
                  {11'd0, OutValid, InReady, OutSat, OutSign, OutExponent, OutMantissa},
                  {11'd0, 1'b1, 1'b0, expSat, expS, expE, expM});
    end
    OutReady = 1'b1;
    #1;
    checkOutput($sformatf("%s_validWithReady", tag), 32'(OutValid), 32'd1);
    @(posedge Clock);
    @(negedge Clock);
    OutReady = 1'b0;
    checkOutput($sformatf("%s_released", tag), {29'd0, OutValid, InReady, OutSat}, {29'd0, 1'b0, 1'b1, 1'b0});
  endtask

  task automatic randomTerm(input int k);
    tSign[k] = 1'($urandom_range(0, 1));
    tExp[k]  = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(58, 63)) : 6'($urandom_range(0, 63));
    tMan[k]  = 12'($urandom);
    if (k > 0 && $urandom_range(0, 5) == 0) begin
      tSign[k] = ~tSign[k-1]; tExp[k] = tExp[k-1]; tMan[k] = tMan[k-1];
    end
  endtask

  initial begin
    Reset = 1'b1; InValid = 1'b0; InSign = 1'b0; InExponent = '0; InMantissa = '0;
    InLast = 1'b0; OutReady = 1'b0;
    repeat (3) @(negedge Clock);
    checkOutput("reset_ctrl", {28'd0, InReady, OutValid, OutSat, 1'b0}, {28'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    checkOutput("reset_count", 32'(OutCount), 32'd0);
    checkOutput("reset_out", {13'd0, OutSign, OutExponent, OutMantissa}, 32'd0);
    checkOutput("reset_addA", {13'd0, AddSignA, AddExponentA, AddMantissaA}, 32'd0);
    checkOutput("reset_addB", {13'd0, AddSignB, AddExponentB, AddMantissaB}, 32'd0);
    Reset = 1'b0;
    @(negedge Clock);

    setTerm(0, 1'b0, 6'd5, 12'h400);
    applyStimulus("single", 1, 1'b0, 0);
    setTerm(0, 1'b0, 6'd5, 12'h800); setTerm(1, 1'b0, 6'd5, 12'h800);
    applyStimulus("carry", 2, 1'b0, 0);
    setTerm(0, 1'b0, 6'd5, 12'h600); setTerm(1, 1'b1, 6'd5, 12'h600);
    applyStimulus("cancel", 2, 1'b0, 1);
    setTerm(0, 1'b0, 6'd63, 12'hC00); setTerm(1, 1'b0, 6'd63, 12'hC00);
    applyStimulus("saturate", 2, 1'b0, 0);
    setTerm(0, 1'b1, 6'd17, 12'h123);
    applyStimulus("stall", 1, 1'b0, 5);

    // Reset arriving while an add is in flight must drop the partial sum.
    setTerm(0, 1'b0, 6'd10, 12'h345); setTerm(1, 1'b0, 6'd9, 12'h9AB); setTerm(2, 1'b1, 6'd3, 12'h111);
    checkOutput("midReset_idleReady", 32'(InReady), 32'd1);
    InValid = 1'b1; InSign = tSign[0]; InExponent = tExp[0]; InMantissa = tMan[0]; InLast = 1'b0;
    @(posedge Clock); @(negedge Clock);
    checkOutput("midReset_fetchReady", 32'(InReady), 32'd1);
    InSign = tSign[1]; InExponent = tExp[1]; InMantissa = tMan[1];
    @(posedge Clock); @(negedge Clock);
    InValid = 1'b0;
    checkOutput("midReset_issueOps", {7'd0, AddExponentA, AddMantissaA, AddExponentB[0], AddMantissaB[5:0]},
                {7'd0, tExp[1+(-1)], tMan[0], tExp[1][0], tMan[1][5:0]});
    @(negedge Clock);
    checkOutput("midReset_waitReady", 32'(InReady), 32'd0);
    Reset = 1'b1;
    #1;
    checkOutput("midReset_ctrl", {29'd0, InReady, OutValid, OutSat}, {29'd0, 1'b1, 1'b0, 1'b0});
    checkOutput("midReset_state", {13'd0, OutCount[0], AddMantissaA, AddExponentB}, 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      checkOutput($sformatf("midReset_noStale%0d", i), {30'd0, OutValid, InReady}, {30'd0, 1'b0, 1'b1});
    end
    setTerm(0, 1'b1, 6'd40, 12'hABC);
    applyStimulus("postReset", 1, 1'b0, 0);

    for (int k = 0; k < CNT_MAX + 2; k++) randomTerm(k);
    applyStimulus("countSat", CNT_MAX + 2, 1'b0, 0);

    for (int t = 0; t < 40; t++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) randomTerm(k);
      applyStimulus($sformatf("rand%0d", t), n, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
